fft_peak_detect: RTL

FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

---
 rtl/fft_pkg.sv | 13 +
 rtl/cplx_mag_sq.sv | 57 +++++
 rtl/fft_peak_detect.sv | 100 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared sizing and FSM encoding for the FFT peak detector.
package fft_pkg;
  localparam int FFT_SIZE_DEF = 2048;
  localparam int BIN_W        = $clog2(FFT_SIZE_DEF);
  localparam int MAG_W        = 32;
  localparam int SAMP_W       = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/cplx_mag_sq.sv
// Three-stage |x|^2 pipeline (capture, squares, sum) with valid/last/bin sideband.
module cplx_mag_sq
  import fft_pkg::*;
#(
  parameter int W_BIN = BIN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [W_BIN-1:0]         in_bin,
  input  logic signed [SAMP_W-1:0] in_re,
  input  logic signed [SAMP_W-1:0] in_im,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [W_BIN-1:0]         out_bin,
  output logic [MAG_W-1:0]         out_mag
);
  logic                     s1_valid, s1_last, s2_valid, s2_last;
  logic [W_BIN-1:0]         s1_bin, s2_bin;
  logic signed [SAMP_W-1:0] s1_re, s1_im;
  logic signed [MAG_W-1:0]  sq_re, sq_im;
  logic [MAG_W-1:0]         s2_re2, s2_im2;

  // Each square is at most 2^30, so the 32-bit product and the sum never overflow.
  assign sq_re = MAG_W'(s1_re) * MAG_W'(s1_re);
  assign sq_im = MAG_W'(s1_im) * MAG_W'(s1_im);

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      out_valid <= s2_valid;
      out_last  <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    s1_re   <= in_re;
    s1_im   <= in_im;
    s1_bin  <= in_bin;
    s2_re2  <= $unsigned(sq_re);
    s2_im2  <= $unsigned(sq_im);
    s2_bin  <= s1_bin;
    out_mag <= s2_re2 + s2_im2;
    out_bin <= s2_bin;
  end
endmodule

// File: rtl/fft_peak_detect.sv
// Finds the largest-magnitude bin of each FFT frame and holds it until consumed.
// state | meaning
// ACCUM | accepting beats of the current frame
// DRAIN | frame end seen, waiting for the magnitude pipeline to empty
// HOLD  | result presented on peak_*, waiting for peak_ready
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int FFT_SIZE = FFT_SIZE_DEF,
  parameter int BIN_LO   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 s_tdata,
  input  logic                        s_tvalid,
  input  logic                        s_tlast,
  output logic                        s_tready,
  output logic [$clog2(FFT_SIZE)-1:0] peak_bin,
  output logic [MAG_W-1:0]            peak_mag,
  output logic                        frame_err,
  output logic                        peak_valid,
  input  logic                        peak_ready
);
  localparam int BW = $clog2(FFT_SIZE);
  localparam logic [BW-1:0] IDX_LAST = BW'(FFT_SIZE - 1);
  localparam logic [BW-1:0] IDX_LO   = BW'(BIN_LO);
  localparam logic [BW-1:0] IDX_HALF = BW'(FFT_SIZE / 2);

  state_t           state, state_nxt;
  logic [BW-1:0]    bin_idx, max_bin, m_bin;
  logic [MAG_W-1:0] max_mag, m_mag;
  logic             accept, at_last, frame_end, cand;
  logic             err_pend, drained, m_valid, m_last;

  assign s_tready   = reset && (state == ST_ACCUM);
  assign peak_valid = (state == ST_HOLD);
  assign accept     = s_tvalid && s_tready;
  assign at_last    = (bin_idx == IDX_LAST);
  assign frame_end  = s_tlast || at_last;
  assign cand       = (bin_idx >= IDX_LO) && (bin_idx < IDX_HALF);

  cplx_mag_sq #(.W_BIN(BW)) u_mag (
    .clk      (clk),
    .reset    (reset),
    .in_valid (accept && cand),
    .in_last  (accept && frame_end),
    .in_bin   (bin_idx),
    .in_re    ($signed(s_tdata[15:0])),
    .in_im    ($signed(s_tdata[31:16])),
    .out_valid(m_valid),
    .out_last (m_last),
    .out_bin  (m_bin),
    .out_mag  (m_mag)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACCUM: if (accept && frame_end) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drained)             state_nxt = ST_HOLD;
      ST_HOLD:  if (peak_ready)          state_nxt = ST_ACCUM;
      default:                           state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_idx   <= '0;
      err_pend  <= 1'b0;
      drained   <= 1'b0;
      max_bin   <= IDX_LO;
      max_mag   <= '0;
      peak_bin  <= '0;
      peak_mag  <= '0;
      frame_err <= 1'b0;
    end else begin
      drained <= m_last;
      if (accept) begin
        bin_idx <= frame_end ? '0 : bin_idx + BW'(1);
        if (frame_end) err_pend <= s_tlast ^ at_last;
      end
      // Publish on the same edge HOLD is entered, and rearm the running max.
      if (drained) begin
        peak_bin  <= max_bin;
        peak_mag  <= max_mag;
        frame_err <= err_pend;
        max_bin   <= IDX_LO;
        max_mag   <= '0;
      end else if (m_valid && (m_mag > max_mag)) begin
        max_bin <= m_bin;
        max_mag <= m_mag;
      end
    end
  end
endmodule
